// File: rtl/pea_pkg.sv
// Shared encodings and limits for the polynomial evaluation accelerator.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package pea_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int MAX_N     = 10;
    localparam int MAX_B     = 31;

    // Firing modes selected by next_mode_in
    typedef enum logic [1:0] {
        NM_SETUP  = 2'd0,
        NM_INSTR  = 2'd1,
        NM_OUTPUT = 2'd2,
        NM_NOP    = 2'd3
    } next_mode_t;

    // Opcodes; OP_BAD is what mode reports for any opcode above OP_RST
    typedef enum logic [2:0] {
        OP_STP = 3'd0,
        OP_EVP = 3'd1,
        OP_EVB = 3'd2,
        OP_RST = 3'd3,
        OP_BAD = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        ST_OK      = 3'd0,
        ST_NO_SLOT = 3'd1,
        ST_BAD_OP  = 3'd2,
        ST_BIG_N   = 3'd3,
        ST_ZERO_B  = 3'd4
    } status_t;

    // Command word layout: [15:14] reserved, [13:9] b, [8:5] N, [4:3] slot, [2:0] opcode
    typedef struct packed {
        logic [1:0] rsvd;
        logic [4:0] b;
        logic [3:0] n;
        logic [1:0] slot;
        logic [2:0] op;
    } cmd_t;

    // Map raw opcode to the reported mode; anything past RST collapses to 7
    function automatic logic [2:0] decode_mode(input logic [2:0] op);
        return (op <= 3'd3) ? op : 3'd7;
    endfunction

endpackage

// File: rtl/pea_horner_mac.sv
// Horner multiply-accumulate: acc <= acc*x + c, 32-bit wrapping, signed 16-bit operands.
// Latency: acc_nxt is combinational; acc updates on the clock edge when en is high.
// Backpressure: none; clr and en are driven by the sequencer every cycle.
module pea_horner_mac
    import pea_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] x,
    input  logic [15:0] c,
    output logic [31:0] acc_nxt
);

    logic [31:0] acc;
    logic [31:0] x_ext;
    logic [31:0] c_ext;

    assign x_ext   = {{16{x[15]}}, x};
    assign c_ext   = {{16{c[15]}}, c};
    // Low 32 bits of the product are identical for signed and unsigned operands
    assign acc_nxt = acc * x_ext + c_ext;

    // Accumulator: cleared before each new x, advanced on every MAC cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= 32'd0;
        end else if (clr) begin
            acc <= 32'd0;
        end else if (en) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/pea_top_module_1.sv
// PEA invoke/datapath core: decodes commands, stores polynomials, evaluates by Horner's rule.
// Latency: SETUP FC 2 cycles after invoke; STP N+2; EVP/EVB b*(deg+2)+1; OUTPUT result_count+1.
// Backpressure: none internally; the enable block only invokes once FIFO occupancy/space suffice.
module pea_top_module_1
    import pea_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] command_in,
    input  logic [15:0] data_in,
    input  logic        invoke,
    input  logic [1:0]  next_mode_in,
    output logic        rd_in_command,
    output logic        rd_in_data,
    output logic        FC,
    output logic        wr_out,
    output logic [31:0] data_out_result,
    output logic [31:0] data_out_status,
    output logic [2:0]  mode,
    output logic [4:0]  b,
    output logic [3:0]  N
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_EVAL  = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;

    cmd_t          cmd_w;
    logic          cmd_unused;
    status_t       setup_status;
    status_t       status_q;
    logic [1:0]    slot_q;

    logic [NUM_SLOTS-1:0] slot_vld;
    logic [3:0]    slot_deg [NUM_SLOTS];
    logic [15:0]   coef     [NUM_SLOTS][MAX_N+1];
    logic [31:0]   res_buf  [MAX_B];

    logic [15:0]   x_q;
    logic [3:0]    cnt;        // coefficient index: load position or Horner step
    logic [4:0]    xcnt;       // x index during EVAL, entry index during EMIT
    logic          mac_phase;  // 0: pop x, 1: MAC steps

    logic [4:0]    res_cnt;
    logic          eval_ok;
    logic          last_x;
    logic          clr_slots;
    logic          mac_clr;
    logic          mac_en;
    logic [31:0]   acc_nxt;

    assign cmd_w      = cmd_t'(command_in);
    assign cmd_unused = ^cmd_w.rsvd;

    assign eval_ok = (status_q == ST_OK) && ((mode == OP_EVP) || (mode == OP_EVB));
    assign res_cnt = ((mode == OP_EVB) && (status_q == ST_OK)) ? b : 5'd1;
    assign last_x  = (xcnt == res_cnt - 5'd1);

    assign data_out_result = (wr_out && eval_ok) ? res_buf[xcnt] : 32'd0;
    assign data_out_status = wr_out ? {29'd0, status_q} : 32'd0;

    // Error classification of the command at the FIFO head, using current slot validity
    always_comb begin
        setup_status = ST_OK;
        case (cmd_w.op)
            OP_STP: if (cmd_w.n > 4'(MAX_N)) setup_status = ST_BIG_N;
            OP_EVP: if (!slot_vld[cmd_w.slot]) setup_status = ST_NO_SLOT;
            OP_EVB: begin
                if (!slot_vld[cmd_w.slot])  setup_status = ST_NO_SLOT;
                else if (cmd_w.b == 5'd0)   setup_status = ST_ZERO_B;
            end
            OP_RST: setup_status = ST_OK;
            default: setup_status = ST_BAD_OP;
        endcase
    end

    // Firing sequencer: next state and one-cycle strobes
    always_comb begin
        state_nxt     = state;
        rd_in_command = 1'b0;
        rd_in_data    = 1'b0;
        wr_out        = 1'b0;
        FC            = 1'b0;
        mac_clr       = 1'b0;
        mac_en        = 1'b0;
        clr_slots     = 1'b0;
        case (state)
            S_IDLE: begin
                if (invoke) begin
                    case (next_mode_in)
                        NM_SETUP:  state_nxt = S_FETCH;
                        NM_INSTR: begin
                            if (status_q != ST_OK) begin
                                state_nxt = S_DONE;
                            end else begin
                                case (mode)
                                    OP_STP:         state_nxt = S_LOAD;
                                    OP_EVP, OP_EVB: state_nxt = S_EVAL;
                                    OP_RST: begin
                                        clr_slots = 1'b1;
                                        state_nxt = S_DONE;
                                    end
                                    default:        state_nxt = S_DONE;
                                endcase
                            end
                        end
                        NM_OUTPUT: state_nxt = S_EMIT;
                        default:   state_nxt = S_DONE;
                    endcase
                end
            end
            S_FETCH: begin
                rd_in_command = 1'b1;
                state_nxt     = S_DONE;
            end
            S_LOAD: begin
                rd_in_data = 1'b1;
                if (cnt == 4'd0) state_nxt = S_DONE;
            end
            S_EVAL: begin
                if (!mac_phase) begin
                    rd_in_data = 1'b1;
                    mac_clr    = 1'b1;
                end else begin
                    mac_en = 1'b1;
                    if ((cnt == 4'd0) && last_x) state_nxt = S_DONE;
                end
            end
            S_EMIT: begin
                wr_out = 1'b1;
                if (last_x) state_nxt = S_DONE;
            end
            S_DONE: begin
                FC        = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts any firing in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Latch and decode the popped command
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode     <= 3'd0;
            b        <= 5'd0;
            N        <= 4'd0;
            slot_q   <= 2'd0;
            status_q <= ST_OK;
        end else if (state == S_FETCH) begin
            mode     <= decode_mode(cmd_w.op);
            b        <= cmd_w.b;
            N        <= cmd_w.n;
            slot_q   <= cmd_w.slot;
            status_q <= setup_status;
        end
    end

    // Slot valid bits and stored degree
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_vld <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) slot_deg[i] <= 4'd0;
        end else if (clr_slots) begin
            slot_vld <= '0;
        end else if ((state == S_LOAD) && (cnt == 4'd0)) begin
            slot_vld[slot_q] <= 1'b1;
            slot_deg[slot_q] <= N;
        end
    end

    // Load/step/entry counters and the current x
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 4'd0;
            xcnt      <= 5'd0;
            mac_phase <= 1'b0;
            x_q       <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (invoke) begin
                        cnt       <= N;
                        xcnt      <= 5'd0;
                        mac_phase <= 1'b0;
                    end
                end
                S_LOAD: cnt <= cnt - 4'd1;
                S_EVAL: begin
                    if (!mac_phase) begin
                        x_q       <= data_in;
                        cnt       <= slot_deg[slot_q];
                        mac_phase <= 1'b1;
                    end else if (cnt == 4'd0) begin
                        xcnt      <= xcnt + 5'd1;
                        mac_phase <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_EMIT: xcnt <= xcnt + 5'd1;
                default: ;
            endcase
        end
    end

    // Coefficient store (first word popped is c_N) and result buffer
    always_ff @(posedge clk) begin
        if (state == S_LOAD) coef[slot_q][cnt] <= data_in;
        if ((state == S_EVAL) && mac_phase && (cnt == 4'd0)) res_buf[xcnt] <= acc_nxt;
    end

    pea_horner_mac u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr     (mac_clr),
        .en      (mac_en),
        .x       (x_q),
        .c       (coef[slot_q][cnt]),
        .acc_nxt (acc_nxt)
    );

endmodule

// File: tb/tb_pea_top_module_1.sv
// Directed bench for pea_top_module_1 with FWFT FIFO models on the inputs.
// Latency: checks FC position per firing against hand-derived cycle counts.
// Backpressure: output FIFOs modelled as always having space.
module tb_pea_top_module_1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] command_in;
    logic [15:0] data_in;
    logic        invoke;
    logic [1:0]  next_mode_in;
    logic        rd_in_command;
    logic        rd_in_data;
    logic        FC;
    logic        wr_out;
    logic [31:0] data_out_result;
    logic [31:0] data_out_status;
    logic [2:0]  mode;
    logic [4:0]  b;
    logic [3:0]  N;

    always #5 clk = ~clk;

    pea_top_module_1 dut (
        .clk             (clk),
        .rst             (rst),
        .command_in      (command_in),
        .data_in         (data_in),
        .invoke          (invoke),
        .next_mode_in    (next_mode_in),
        .rd_in_command   (rd_in_command),
        .rd_in_data      (rd_in_data),
        .FC              (FC),
        .wr_out          (wr_out),
        .data_out_result (data_out_result),
        .data_out_status (data_out_status),
        .mode            (mode),
        .b               (b),
        .N               (N)
    );

    // FWFT input FIFO models: head word presented combinationally, popped on the edge
    logic [15:0] cmd_mem [16];
    logic [15:0] dat_mem [16];
    logic [3:0]  cmd_idx = 4'd0;
    logic [3:0]  dat_idx = 4'd0;
    logic        pop_cmd = 1'b0;
    logic        pop_dat = 1'b0;

    assign command_in = cmd_mem[cmd_idx];
    assign data_in    = dat_mem[dat_idx];

    always @(posedge clk) begin
        if (rst) begin
            if (pop_cmd) cmd_idx <= cmd_idx + 4'd1;
            if (pop_dat) dat_idx <= dat_idx + 4'd1;
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_rd_cmd;
    int          n_rd_dat;
    int          n_wr;
    int          fc_seen;
    logic [31:0] wr_res [32];
    logic [31:0] wr_sts [32];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One firing: invoke, watch strobes until FC (bounded), check FC position and pop counts.
    // busy_at > 0 raises a SETUP invoke on that cycle while the firing is still in progress.
    task automatic fire(input string tag, input logic [1:0] m, input int lat_exp,
                        input int cmd_exp, input int dat_exp, input int busy_at);
        int lat;
        lat      = -1;
        n_rd_cmd = 0;
        n_rd_dat = 0;
        n_wr     = 0;
        @(negedge clk);
        invoke       = 1'b1;
        next_mode_in = m;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            invoke       = (i == busy_at);
            next_mode_in = (i == busy_at) ? 2'd0 : m;
            pop_cmd      = rd_in_command;
            pop_dat      = rd_in_data;
            if (rd_in_command) n_rd_cmd++;
            if (rd_in_data)    n_rd_dat++;
            if (wr_out && (n_wr < 32)) begin
                wr_res[n_wr] = data_out_result;
                wr_sts[n_wr] = data_out_status;
                n_wr++;
            end
            if (FC) begin
                lat = i;
                break;
            end
        end
        invoke  = 1'b0;
        pop_cmd = 1'b0;
        pop_dat = 1'b0;
        check_eq({tag, "_fc_cycle"}, 32'(lat), 32'(lat_exp));
        check_eq({tag, "_cmd_pops"}, 32'(n_rd_cmd), 32'(cmd_exp));
        check_eq({tag, "_dat_pops"}, 32'(n_rd_dat), 32'(dat_exp));
    endtask

    task automatic setup(input string tag, input int exp_mode, input int exp_b, input int exp_n);
        fire({tag, "_setup"}, 2'd0, 2, 1, 0, 0);
        check_eq({tag, "_mode"}, 32'(mode), 32'(exp_mode));
        check_eq({tag, "_b"},    32'(b),    32'(exp_b));
        check_eq({tag, "_N"},    32'(N),    32'(exp_n));
    endtask

    task automatic out1(input string tag, input logic [31:0] exp_res, input int exp_sts);
        fire({tag, "_out"}, 2'd2, 2, 0, 0, 0);
        check_eq({tag, "_wr_count"}, 32'(n_wr), 32'd1);
        check_eq({tag, "_result"}, wr_res[0], exp_res);
        check_eq({tag, "_status"}, wr_sts[0], 32'(exp_sts));
    endtask

    logic [31:0] evb_exp [3];

    initial begin
        for (int i = 0; i < 16; i++) begin
            cmd_mem[i] = 16'h0000;
            dat_mem[i] = 16'h0000;
        end
        // Commands: op | slot<<3 | N<<5 | b<<9
        cmd_mem[0]  = 16'h0040;  // STP slot0 N=2
        cmd_mem[1]  = 16'h0001;  // EVP slot0
        cmd_mem[2]  = 16'h0602;  // EVB slot0 b=3
        cmd_mem[3]  = 16'h0009;  // EVP slot1
        cmd_mem[4]  = 16'h0005;  // opcode 5
        cmd_mem[5]  = 16'h0170;  // STP slot2 N=11
        cmd_mem[6]  = 16'h0002;  // EVB slot0 b=0
        cmd_mem[7]  = 16'h0003;  // RST
        cmd_mem[8]  = 16'h0001;  // EVP slot0
        cmd_mem[9]  = 16'h0240;  // STP slot0 N=2 b=1 (aborted by reset)
        cmd_mem[10] = 16'h0001;  // EVP slot0
        cmd_mem[11] = 16'h0058;  // STP slot3 N=2
        cmd_mem[12] = 16'h0019;  // EVP slot3
        dat_mem[0]  = 16'd1;     // c2
        dat_mem[1]  = 16'd2;     // c1
        dat_mem[2]  = 16'd3;     // c0
        dat_mem[3]  = 16'd2;     // EVP x
        dat_mem[4]  = 16'd0;     // EVB x values
        dat_mem[5]  = 16'd1;
        dat_mem[6]  = 16'hFFFF;
        dat_mem[7]  = 16'h8000;  // slot3 coefficients, all -32768
        dat_mem[8]  = 16'h8000;
        dat_mem[9]  = 16'h8000;
        dat_mem[10] = 16'h8000;  // slot3 x = -32768
        evb_exp[0]  = 32'd3;
        evb_exp[1]  = 32'd6;
        evb_exp[2]  = 32'd2;

        rst          = 1'b0;
        invoke       = 1'b0;
        next_mode_in = 2'd0;
        #22;
        check_eq("reset_strobes", 32'({rd_in_command, rd_in_data, FC, wr_out}), 32'd0);
        check_eq("reset_result", data_out_result, 32'd0);
        check_eq("reset_status", data_out_status, 32'd0);
        check_eq("reset_mode_b_n", 32'({mode, b, N}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // p(x) = x^2 + 2x + 3 in slot0
        setup("stp0", 0, 0, 2);
        fire("stp0_instr", 2'd1, 4, 0, 3, 0);
        out1("stp0", 32'd0, 0);

        setup("evp0", 1, 0, 0);
        fire("evp0_instr", 2'd1, 5, 0, 1, 0);
        out1("evp0", 32'd11, 0);

        setup("evb0", 2, 3, 0);
        fire("evb0_instr", 2'd1, 13, 0, 3, 0);
        fire("evb0_out", 2'd2, 4, 0, 0, 0);
        check_eq("evb0_wr_count", 32'(n_wr), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("evb0_result%0d", k), wr_res[k], evb_exp[k]);
            check_eq($sformatf("evb0_status%0d", k), wr_sts[k], 32'd0);
        end

        setup("evp1", 1, 0, 0);
        fire("evp1_instr", 2'd1, 1, 0, 0, 0);
        out1("evp1", 32'd0, 1);

        setup("badop", 7, 0, 0);
        fire("badop_instr", 2'd1, 1, 0, 0, 0);
        out1("badop", 32'd0, 2);

        setup("stpbig", 0, 0, 11);
        fire("stpbig_instr", 2'd1, 1, 0, 0, 0);
        out1("stpbig", 32'd0, 3);

        setup("evbb0", 2, 0, 0);
        fire("evbb0_instr", 2'd1, 1, 0, 0, 0);
        out1("evbb0", 32'd0, 4);

        fire("nop", 2'd3, 1, 0, 0, 0);

        setup("rstop", 3, 0, 0);
        fire("rstop_instr", 2'd1, 1, 0, 0, 0);
        out1("rstop", 32'd0, 0);

        setup("evp_cleared", 1, 0, 0);
        fire("evp_cleared_instr", 2'd1, 1, 0, 0, 0);
        out1("evp_cleared", 32'd0, 1);

        // Reset in the middle of an STP load
        setup("abort", 0, 1, 2);
        @(negedge clk);
        invoke       = 1'b1;
        next_mode_in = 2'd1;
        @(negedge clk);
        invoke = 1'b0;
        check_eq("abort_loading", 32'(rd_in_data), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("abort_strobes", 32'({rd_in_command, rd_in_data, FC, wr_out}), 32'd0);
        check_eq("abort_result", data_out_result, 32'd0);
        check_eq("abort_status", data_out_status, 32'd0);
        check_eq("abort_mode_b_n", 32'({mode, b, N}), 32'd0);
        fc_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (FC) fc_seen++;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (FC) fc_seen++;
        end
        check_eq("abort_no_fc", 32'(fc_seen), 32'd0);

        setup("evp_abort", 1, 0, 0);
        fire("evp_abort_instr", 2'd1, 1, 0, 0, 0);
        out1("evp_abort", 32'd0, 1);

        // Wrapping arithmetic in slot3, with a stray invoke during the load
        setup("stp3", 0, 0, 2);
        fire("stp3_instr_busy", 2'd1, 4, 0, 3, 2);
        setup("evp3", 1, 0, 0);
        fire("evp3_instr", 2'd1, 5, 0, 1, 0);
        out1("evp3", 32'h3FFF8000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pea_top_module_1.md
# pea_top_module_1

Invoke/datapath core of the Polynomial Evaluation Accelerator (PEA), a three-mode CFDF actor. It pops commands and coefficient/x data from two 16-bit first-word-fall-through input FIFOs, stores up to four polynomials, and evaluates them with Horner's rule. It pushes one result word and one status word per evaluation into two 32-bit output FIFOs. `PEA_enable` uses the exported `mode`/`b`/`N` to decide when a firing may be invoked.

## Interface
- `NUM_SLOTS`, 4: number of polynomial storage slots.
- `MAX_N`, 10: maximum polynomial degree.
- `MAX_B`, 31: maximum batch size.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, **asynchronous, active-low**.
- `command_in` input 16: head word of the command FIFO.
- `data_in` input 16: head word of the data FIFO.
- `invoke` input 1: one-cycle firing request.
- `next_mode_in` input 2: firing mode. 0 SETUP_INSTR, 1 INSTR, 2 OUTPUT; 3 is a no-op firing.
- `rd_in_command` output 1: command FIFO pop strobe.
- `rd_in_data` output 1: data FIFO pop strobe.
- `FC` output 1: firing-complete pulse.
- `wr_out` output 1: push strobe shared by both output FIFOs.
- `data_out_result` output 32: result word.
- `data_out_status` output 32: status word, zero-extended.
- `mode` output 3: decoded instruction.
- `b` output 5: batch size of the current instruction.
- `N` output 4: degree of the current instruction.

## Operation
- Command fields:
  - `cmd[2:0]` is the opcode: 0 STP, 1 EVP, 2 EVB, 3 RST; 4–7 are invalid.
  - `cmd[4:3]` is the slot.
  - `cmd[8:5]` is N.
  - `cmd[13:9]` is b.
  - `cmd[15:14]` are ignored.
- `mode` equals the opcode. Invalid opcodes report mode 7.
- Status codes: 0 OK, 1 undefined slot, 2 invalid opcode, 3 N>MAX_N, 4 b=0.
- Error status is determined in SETUP_INSTR.
- Mode SETUP_INSTR: pop exactly one command, then latch and decode it. Update `mode`, `b`, `N` and the pending status.
- Mode INSTR:
  - STP, valid N: pop N+1 data words. The first word is c_N, the last is c_0. Store them in the slot and set the slot's valid bit.
  - STP with N>MAX_N: pops nothing.
  - EVP, slot valid: pop one x and compute one result.
  - EVB, slot valid and b≥1: pop b x values and compute b results. Results are buffered internally, depth MAX_B.
  - Evaluation uses the slot's stored degree; the command's N field is ignored for EVP/EVB.
  - Any error: pop no data.
  - RST: clear all slot valid bits, pop nothing.
- Mode OUTPUT:
  - Push `result_count` entries. This is b for a valid EVB, otherwise 1.
  - Each push carries the result and the status.
  - Error and RST/STP entries carry result 0.
- Arithmetic:
  - Coefficients and x are signed 16-bit, sign-extended.
  - Horner step: acc ← acc·x + c_i, starting with acc = 0.
  - 32-bit two's-complement wrap, no saturation.
- Enable contract, implemented in `PEA_enable`:
  - SETUP_INSTR needs 1 or more commands.
  - INSTR needs, by case: N+1 data words for STP, 1 for EVP, b for EVB, and 0 for errors/RST.
  - OUTPUT needs free space ≥ result_count in both output FIFOs.

## Timing
- Reset values: every output is 0, all slot valid bits are 0, and the FSM is IDLE.
- Reset mid-firing aborts immediately. No FC is issued.
- FSM states: IDLE → FETCH/LOAD/EVAL/EMIT → DONE → IDLE.
- `invoke` and `next_mode_in` are sampled only in IDLE. `invoke` in any other state is ignored.
- SETUP_INSTR:
  - invoke seen at edge T.
  - `rd_in_command`=1 during cycle T+1, and `command_in` is latched at T+2.
  - `FC`=1 during cycle T+2.
- STP:
  - `rd_in_data` high for N+1 consecutive cycles, latching `data_in` each cycle.
  - The FIFO presents the next word in the cycle after a pop.
  - FC follows in the next cycle.
- Evaluation, per x:
  - 1 pop cycle, then N+1 MAC cycles.
  - FC follows in the cycle after the last result.
- OUTPUT: `wr_out` high for result_count consecutive cycles, one entry per cycle, with data valid during the same cycle. FC follows in the next cycle.
- Error, RST or next_mode 3 in INSTR: FC in the cycle after invoke, with no strobes.
- `FC`, `rd_in_*` and `wr_out` are one-cycle-wide pulses.
- `mode`, `b`, `N` hold their values until the next SETUP_INSTR.

## Structure
- Shared package `pea_pkg`: mode encodings, opcode encodings, status codes, MAX_N, MAX_B, NUM_SLOTS, and command field positions.
- Natural sub-module: `pea_horner_mac`, a 32-bit multiply-accumulate with clear.
- Coefficient storage: NUM_SLOTS×(MAX_N+1)×16-bit register file plus per-slot degree/valid.
- The FIFOs (`fifo`) and `PEA_enable` are separate blocks.

## Test plan
- STP slot0 N=2, coefficients 1,2,3: SETUP FC 2 cycles after invoke, `mode`=0, `N`=2. INSTR shows 3 pops then FC. OUTPUT pushes result 0, status 0.
- EVP slot0 x=2: result 11, status 0, exactly one `wr_out`.
- EVB slot0 b=3, x=0,1,−1: results 3, 6, 2 on three consecutive `wr_out` cycles, status 0 each.
- EVP slot1 (never set): no data pop, result 0, status 1. Opcode 5: `mode`=7, status 2.
- STP N=11: status 3, no data popped. EVB b=0: status 4. RST then EVP slot0: status 1.
- Reset pulsed during the STP load: all outputs 0 at once, no FC. Slot0 is invalid afterwards. A second `invoke` while busy has no effect.
